// File: rtl/csr_uart_fifo_if.sv
// CSR bus bundle between the CPU pipeline (master) and a CSR peripheral (slave).
interface csr_uart_fifo_if;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;

  modport master (output read, modify, wdata, addr, input rdata, valid);
  modport slave  (input read, modify, wdata, addr, output rdata, valid);
endinterface

// File: rtl/csr_uart_fifo.sv
// Buffered 8N1 UART on the CSR bus with RX/TX byte FIFOs and a sticky RX overflow flag.
// Optional feature macro: CSR_UART_FIFO_IRQ_EN (registered RX-pending interrupt).
module csr_uart_fifo #(
  parameter logic [11:0] BASE_ADDR  = 12'hBC0,
  parameter int          CLOCK_RATE = 200_000_000,
  parameter int          BAUD_RATE  = 115200,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rstn,
  csr_uart_fifo_if.slave bus,
  input  logic           rx,
  output logic           tx,
  output logic           irq
);
  localparam int DIV   = CLOCK_RATE / BAUD_RATE;
  localparam int CW    = $clog2(DIV);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]    rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    rx_mem_d [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    tx_mem_d [DEPTH];
  logic          ovf_q, ovf_d, tx_q, tx_d;

  logic       sel, csr_wr, csr_pop;
  logic       rx_empty, rx_full, tx_empty, tx_full, tx_idle;
  logic       rx_push_req, rx_push, ovf_set, tx_push, tx_pop, tx_load;
  logic [7:0] rx_head, tx_head;
  logic       unused_wdata;

  assign sel      = (bus.addr == BASE_ADDR);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[PW-1] != rx_rd_q[PW-1]) && (rx_wr_q[PW-2:0] == rx_rd_q[PW-2:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[PW-1] != tx_rd_q[PW-1]) && (tx_wr_q[PW-2:0] == tx_rd_q[PW-2:0]);
  assign rx_head  = rx_mem_q[rx_rd_q[PW-2:0]];
  assign tx_head  = tx_mem_q[tx_rd_q[PW-2:0]];
  assign csr_pop  = sel & bus.read & ~rx_empty;
  assign csr_wr   = sel & (bus.modify != 3'b000);
  assign tx_push  = csr_wr & ~tx_full;
  assign tx_idle  = tx_empty & (tx_state_q == ST_IDLE);

  assign bus.valid = sel;
  assign bus.rdata = sel ? {20'h0, tx_idle, tx_full, ovf_q, ~rx_empty, rx_empty ? 8'h00 : rx_head}
                         : 32'h0;
  assign tx = tx_q;
  assign unused_wdata = ^{bus.wdata[31:10], bus.wdata[8]};

  // Receiver: start is confirmed half a bit in, then every bit is sampled mid-cell.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + CW'(1);
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push_req = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = ST_START;
      end
      ST_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_cnt_q == DIV_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
      end
      default: if (rx_cnt_q == DIV_LAST) begin
        rx_cnt_d    = '0;
        rx_state_d  = ST_IDLE;
        rx_push_req = rx_s2_q;
      end
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  always_comb begin
    rx_push  = rx_push_req & (~rx_full | csr_pop);
    ovf_set  = rx_push_req & rx_full & ~csr_pop;
    rx_wr_d  = rx_wr_q + PW'(rx_push);
    rx_rd_d  = rx_rd_q + PW'(csr_pop);
    tx_wr_d  = tx_wr_q + PW'(tx_push);
    tx_rd_d  = tx_rd_q + PW'(tx_pop);
    rx_mem_d = rx_mem_q;
    tx_mem_d = tx_mem_q;
    if (rx_push) rx_mem_d[rx_wr_q[PW-2:0]] = rx_shift_q;
    if (tx_push) tx_mem_d[tx_wr_q[PW-2:0]] = bus.wdata[7:0];
    ovf_d = ovf_q;
    if (csr_wr && bus.wdata[9]) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  assign tx_load = ~tx_empty & ((tx_state_q == ST_IDLE) ||
                                ((tx_state_q == ST_STOP) && (tx_cnt_q == DIV_LAST)));

  // Transmitter: loading straight out of STOP keeps back-to-back frames gapless.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    if (tx_load) begin
      tx_state_d = ST_START;
      tx_cnt_d   = '0;
      tx_shift_d = tx_head;
      tx_d       = 1'b0;
      tx_pop     = 1'b1;
    end else begin
      case (tx_state_q)
        ST_IDLE: tx_cnt_d = '0;
        ST_START: if (tx_cnt_q == DIV_LAST) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
        end
        ST_DATA: if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_d = tx_shift_q[1];
          end
        end
        default: if (tx_cnt_q == DIV_LAST) begin
          tx_state_d = ST_IDLE;
          tx_cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_mem_q   <= '{default: 8'h00};
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_mem_q   <= '{default: 8'h00};
      ovf_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_mem_q   <= rx_mem_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_mem_q   <= tx_mem_d;
      ovf_q      <= ovf_d;
      tx_q       <= tx_d;
    end
  end

`ifdef CSR_UART_FIFO_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = ~rx_empty | ovf_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: doc/csr_uart_fifo.md
# csr_uart_fifo

Buffered UART peripheral on the pipeline's CSR bus, the stage between the `uart_rx`/`uart_tx` board pins and the CPU.
- It replaces the single-character UART slot with independent RX and TX byte FIFOs, 8N1 framing and a sticky RX overflow flag.
- Its `rdata`/`valid` outputs are OR-ed into the shared CSR read mux alongside the other CSR peripherals.

## Interface
- `BASE_ADDR`, 12'hBC0: CSR address decoded by this block.
- `CLOCK_RATE`, 200_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud.
- `DEPTH_LOG2`, 4: each FIFO holds 2^DEPTH_LOG2 bytes.

Ports:
- `clk` in 1: the single clock.
- `rstn` in 1: reset, **asynchronous and active-low**.
- `read` in 1: CSR read strobe.
- `modify` in 3: CSR write op; 000 means no write, any other value means write.
- `wdata` in 32: CSR write data.
- `addr` in 12: CSR address.
- `rdata` out 32: read data; 0 when not selected.
- `valid` out 1: `addr == BASE_ADDR`.
- `rx` in 1: serial input, asynchronous to `clk`.
- `tx` out 1: serial output.
- `irq` out 1: RX data pending (see Configuration).

## Operation
- `DIV = CLOCK_RATE/BAUD_RATE`, truncated integer; DIV ≥ 4 is required.
- Status word returned in `rdata` when selected:
  - [7:0]: RX head byte, 0 if the RX FIFO is empty.
  - [8]: RX FIFO non-empty.
  - [9]: RX overflow, sticky.
  - [10]: TX FIFO full.
  - [11]: TX idle (TX FIFO empty and shifter idle).
  - [31:12]: 0.
- CSR read (`read=1`, address match) while the RX FIFO is non-empty pops the head byte at the clock edge. A read while the RX FIFO is empty has no side effect.
- CSR write (`modify≠0`, address match):
  - `wdata[7:0]` is pushed into the TX FIFO unless it is full; a write to a full FIFO is dropped silently.
  - If `wdata[9]=1`, the overflow flag is cleared.
  - `wdata[8]` is ignored.
- A read-modify CSR access (both `read` and `modify` active) performs the pop and the push in the same cycle.
- RX path:
  - `rx` passes through a 2-flop synchronizer.
  - States: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
  - IDLE→START on a synchronized falling edge.
  - START: after DIV/2 cycles, if the line is still 0 go to DATA, otherwise back to IDLE (glitch).
  - DATA and STOP: sample once every DIV cycles.
  - STOP sample = 1: push the byte. If the FIFO is full and no pop happens in the same cycle, the byte is discarded and overflow is set.
  - STOP sample = 0: framing error; the byte is discarded silently.
- TX path:
  - States: IDLE → START → DATA ×8 → STOP → IDLE, each bit lasting exactly DIV cycles.
  - IDLE loads from the TX FIFO whenever it is non-empty.
  - Back-to-back bytes have no idle gap.
- FIFO pointers are DEPTH_LOG2+1 bits wide and wrap naturally. Full means the MSBs differ and the other bits are equal.
- Simultaneous pop and push on a full RX FIFO: both take effect, no overflow. Simultaneous pop and push on an empty FIFO: the push is accepted and the pop is ignored.

## Timing
- Reset values:
  - `tx=1`, `irq=0`, both FIFOs empty, overflow=0, both FSMs IDLE.
  - `rdata`/`valid` follow `addr` combinationally.
- Reset asserted mid-frame aborts the frame immediately: `tx` returns to 1 asynchronously.
- `rdata` and `valid` are combinational from `addr` and registered state. The popped or pushed effect is visible the cycle after the access.
- RX latency: from the start-bit falling edge on `rx` to bit 8 = 1 is 2 (synchronizer) + DIV/2 + 9·DIV + 1 cycles.
- TX latency: a write on cycle n puts the start bit on `tx` at n+2, if the shifter was idle.

## Configuration
- `CSR_UART_FIFO_IRQ_EN` defined:
  - `irq` is registered, high whenever the RX FIFO is non-empty or overflow is set.
  - `irq` updates one cycle after the FIFO state changes.
- `CSR_UART_FIFO_IRQ_EN` undefined:
  - `irq` is tied to 0 and no irq logic is synthesized.
- The CSR behaviour is identical in both builds.

## Test plan
All scenarios use `CLOCK_RATE=64`, `BAUD_RATE=4` (DIV=16) and `DEPTH_LOG2=2`.
- **Reset:** assert `rstn=0` mid-TX-frame → `tx=1` immediately. After release, a read at 12'hBC0 returns 32'h800 (idle, empty).
- **TX:** write 8'hA5 → `tx` shows start 0, bits 1,0,1,0,0,1,0,1, stop 1. Each bit lasts 16 cycles and the start bit begins 2 cycles after the write.
- **RX:** drive 8'h3C serially, then read → `rdata=32'h93C` (byte + non-empty + TX idle). The next read returns 32'h800.
- **Overflow:** receive 5 bytes 01..05 with no reads → bit 9 set and bytes 01..04 pop in order. A write with `wdata[9]=1` clears bit 9.
- **Framing and glitch:**
  - A stop bit of 0 → no byte is pushed.
  - A 3-cycle low pulse on `rx` → RX returns to IDLE, no byte is pushed.
- **Full-FIFO boundary:** with the RX FIFO full, a byte's stop sample coincides with a CSR read pop → no overflow, 4 bytes remain. Separately, 6 rapid TX writes → only the first 5 bytes are transmitted (1 in the shifter + 4 in the FIFO).
- **IRQ (IRQ_EN build only):** `irq` rises 1 cycle after the RX push and falls 1 cycle after the final pop.
